// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: Result = A - B, one bit per clock,
//   LSB first, with a registered borrow chain. Operands are captured on an
//   accepted start. Result and flags are loaded together on the last bit.
//   After that load, done pulses for one cycle and the values hold until the
//   next load.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all state and outputs
//   start    request, sampled only while busy = 0
//   A, B     minuend / subtrahend, captured on accepted start
//   busy     high while a subtraction is in progress
//   done     one-cycle pulse: Result/flags were just updated
//   Result   A - B mod 2^WIDTH
//   Borrow   final borrow (1 when A < B unsigned)
//   Zero     Result == 0
//   Overflow signed overflow of A - B
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Borrow,
  output logic             Zero,
  output logic             Overflow
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Full-subtractor difference bit.
  function automatic logic diff_bit(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  // Full-subtractor borrow out.
  function automatic logic borrow_bit(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // State registers
  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] r_sh_r;
  logic             borrow_r;
  logic [CW-1:0]    count_r;
  logic             a_msb_r;
  logic             b_msb_r;

  // Next-state values
  logic [1:0]       state_s;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_s;
  logic [WIDTH-1:0] r_sh_s;
  logic             borrow_s;
  logic [CW-1:0]    count_s;
  logic             a_msb_s;
  logic             b_msb_s;
  logic             busy_s;
  logic             done_s;
  logic [WIDTH-1:0] result_s;
  logic             borrow_out_s;
  logic             zero_s;
  logic             overflow_s;

  // Per-bit datapath terms
  logic             d_s;
  logic             borrow_next_s;
  logic [WIDTH-1:0] r_next_s;

  // Next-state and output-load logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s      = state_r;
    a_sh_s       = a_sh_r;
    b_sh_s       = b_sh_r;
    r_sh_s       = r_sh_r;
    borrow_s     = borrow_r;
    count_s      = count_r;
    a_msb_s      = a_msb_r;
    b_msb_s      = b_msb_r;
    busy_s       = busy;
    done_s       = 1'b0;
    result_s     = Result;
    borrow_out_s = Borrow;
    zero_s       = Zero;
    overflow_s   = Overflow;

    d_s           = diff_bit(a_sh_r[0], b_sh_r[0], borrow_r);
    borrow_next_s = borrow_bit(a_sh_r[0], b_sh_r[0], borrow_r);
    // Difference bits enter from the MSB end so that after WIDTH shifts bit 0
    // sits at position 0.
    r_next_s      = {d_s, r_sh_r[WIDTH-1:1]};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s  = ST_RUN;
          a_sh_s   = A;
          b_sh_s   = B;
          r_sh_s   = {WIDTH{1'b0}};
          borrow_s = 1'b0;
          count_s  = {CW{1'b0}};
          a_msb_s  = A[WIDTH-1];
          b_msb_s  = B[WIDTH-1];
          busy_s   = 1'b1;
        end else begin
          state_s  = ST_IDLE;
          busy_s   = 1'b0;
        end
      end

      ST_RUN: begin
        a_sh_s   = {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_s   = {1'b0, b_sh_r[WIDTH-1:1]};
        r_sh_s   = r_next_s;
        borrow_s = borrow_next_s;
        count_s  = count_r + CW'(1);
        if (count_r == LAST_CNT) begin
          // Last bit: publish the complete result and flags at once.
          state_s      = ST_DONE;
          busy_s       = 1'b0;
          done_s       = 1'b1;
          result_s     = r_next_s;
          borrow_out_s = borrow_next_s;
          zero_s       = (r_next_s == {WIDTH{1'b0}});
          // Overflow only possible when operand signs differ and the result
          // sign departs from the minuend sign.
          overflow_s   = (a_msb_r != b_msb_r) && (r_next_s[WIDTH-1] != a_msb_r);
        end else begin
          state_s      = ST_RUN;
          busy_s       = 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Sequencer, datapath and registered outputs; reset discards any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      r_sh_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      count_r  <= {CW{1'b0}};
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= {WIDTH{1'b0}};
      Borrow   <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_sh_r   <= a_sh_s;
      b_sh_r   <= b_sh_s;
      r_sh_r   <= r_sh_s;
      borrow_r <= borrow_s;
      count_r  <= count_s;
      a_msb_r  <= a_msb_s;
      b_msb_r  <= b_msb_s;
      busy     <= busy_s;
      done     <= done_s;
      Result   <= result_s;
      Borrow   <= borrow_out_s;
      Zero     <= zero_s;
      Overflow <= overflow_s;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
//   A cycle-level behavioural model computes expected outputs from plain
//   integer arithmetic. One compare process checks both DUTs on every falling
//   edge. Directed operations add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  res8;
  logic        brw8, zero8, ovf8;

  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] res16;
  logic        brw16, zero16, ovf16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Result(res8),
    .Borrow(brw8), .Zero(zero8), .Overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Result(res16),
    .Borrow(brw16), .Zero(zero16), .Overflow(ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  // Expected {result[15:0], borrow, zero, overflow} from integer arithmetic.
  function automatic logic [18:0] expect_op(input int w, input int a, input int b);
    int          span, half, sa, sb, sd;
    logic [15:0] res;
    logic        brw, ovf;
    span = 1 << w;
    half = span / 2;
    res  = 16'((a - b + span) % span);
    brw  = (a < b);
    sa   = (a >= half) ? a - span : a;
    sb   = (b >= half) ? b - span : b;
    sd   = sa - sb;
    ovf  = (sd >= half) || (sd < -half);
    return {res, brw, (res == 16'd0), ovf};
  endfunction

  // Behavioural model: accept when idle, publish WIDTH edges later.
  logic        m_busy [2];
  logic        m_done [2];
  logic [18:0] m_out  [2];
  int          m_left [2];
  int          m_a    [2];
  int          m_b    [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_out[i]  <= 19'd0;
        m_left[i] <= 0;
        m_a[i]    <= 0;
        m_b[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_left[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_out[i]  <= expect_op(wid(i), m_a[i], m_b[i]);
          end
          m_left[i] <= m_left[i] - 1;
        end else if ((i == 0) ? start8 : start16) begin
          m_busy[i] <= 1'b1;
          m_left[i] <= wid(i);
          m_a[i]    <= (i == 0) ? int'(a8) : int'(a16);
          m_b[i]    <= (i == 0) ? int'(b8) : int'(b16);
        end
      end
    end
  end

  // Compare process: every falling edge, both DUTs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("dut8 cycle",
            {11'd0, busy8, done8, 8'h00, res8, brw8, zero8, ovf8},
            {11'd0, m_busy[0], m_done[0], m_out[0]});
      check("dut16 cycle",
            {11'd0, busy16, done16, res16, brw16, zero16, ovf16},
            {11'd0, m_busy[1], m_done[1], m_out[1]});
    end
  end

  // One directed 8-bit operation with literal expectations.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic eb, input logic ez,
                        input logic eo, input bit toggle);
    int         lat, busy_cnt;
    bit         found, held;
    logic [7:0] prev;
    prev   = res8;
    held   = 1'b1;
    a8     = a;
    b8     = b;
    start8 = 1'b1;
    @(negedge clk);
    start8   = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    found    = 1'b0;
    while (!found && lat < 20) begin
      if (done8) begin
        found = 1'b1;
      end else begin
        if (busy8) busy_cnt++;
        if (res8 !== prev) held = 1'b0;
        if (toggle) begin
          start8 = ~start8;
          a8     = 8'($urandom);
          b8     = 8'($urandom);
        end
        @(negedge clk);
        lat++;
      end
    end
    start8 = 1'b0;
    check({name, " done seen"},   32'(found),    32'd1);
    check({name, " latency"},     32'(lat),      32'd8);
    check({name, " busy cycles"}, 32'(busy_cnt), 32'd8);
    check({name, " held"},        32'(held),     32'd1);
    check({name, " result"},      32'(res8),     32'(er));
    check({name, " borrow"},      32'(brw8),     32'(eb));
    check({name, " zero"},        32'(zero8),    32'(ez));
    check({name, " overflow"},    32'(ovf8),     32'(eo));
  endtask

  initial begin
    int extra;
    reset   = 1'b1;
    start8  = 1'b0;
    a8      = 8'h00;
    b8      = 8'h00;
    start16 = 1'b0;
    a16     = 16'h0000;
    b16     = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle outputs8",  32'({busy8, done8, res8, brw8, zero8, ovf8}), 32'd0);
      check("idle outputs16", 32'({busy16, done16, res16, brw16, zero16, ovf16}), 32'd0);
    end

    run_op("5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("37-37", 8'h37, 8'h37, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("10-01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("C3-5A toggle", 8'hC3, 8'h5A, 8'h69, 1'b0, 1'b0, 1'b1, 1'b1);

    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("toggle extra done", 32'(extra), 32'd0);

    // Reset in the middle of an operation on both instances.
    a8      = 8'hAA;
    b8      = 8'h55;
    start8  = 1'b1;
    a16     = 16'h1234;
    b16     = 16'h4321;
    start16 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset8",  32'({busy8, done8, res8, brw8, zero8, ovf8}), 32'd0);
    check("async reset16", 32'({busy16, done16, res16, brw16, zero16, ovf16}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || done16) extra++;
    end
    check("done after reset", 32'(extra), 32'd0);

    // Back-to-back random regression with start held high.
    fork
      begin
        int ops8, cyc8;
        ops8   = 0;
        cyc8   = 0;
        start8 = 1'b1;
        while (ops8 < 3000 && cyc8 < 40000) begin
          a8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
          b8 = ($urandom_range(0, 7) == 0) ? 8'h7F : 8'($urandom);
          @(negedge clk);
          cyc8++;
          if (done8) ops8++;
        end
        start8 = 1'b0;
        check("random ops8", 32'(ops8), 32'd3000);
      end
      begin
        int ops16, cyc16;
        ops16   = 0;
        cyc16   = 0;
        start16 = 1'b1;
        while (ops16 < 1500 && cyc16 < 40000) begin
          a16 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
          b16 = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
          @(negedge clk);
          cyc16++;
          if (done16) ops16++;
        end
        start16 = 1'b0;
        check("random ops16", 32'(ops16), 32'd1500);
      end
    join

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
